ifetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a prefetch FIFO. It replaces the single-register fetch stage of the mips32 pipeline. It holds a word-addressed instruction memory with a program-load port and runs the PC ahead of decode. Fetched words are buffered in a DEPTH-entry queue and handed to decode through a valid/ready handshake. It supports branch redirect with flush and stops fetching on a HALT opcode.

---
 rtl/ifetch_queue.sv | 173 +++++++++++++++++
 tb/tb_ifetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Generic circular FIFO with synchronous flush and a zeroed head when empty.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: no internal stall; the caller must never push into a full queue.
module ifetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_eff;
    logic          pop_eff;

    assign push_eff = push && !flush;
    assign pop_eff  = pop && (cnt != '0) && !flush;
    assign head_vld = (cnt != '0);
    assign head_dat = head_vld ? store[rd_ptr] : '0;
    assign count    = cnt;

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            store[wr_ptr] <= push_dat;
        end
    end
endmodule

// Instruction fetch: word-addressed imem, PC running ahead into a prefetch queue.
// Latency: two edges from issue to head (sync read, then enqueue); 1 instr/cycle steady.
// Backpressure: out_ready low fills the queue; issue stops while queue + in-flight read is full.
module ifetch_queue #(
    parameter int             XLEN    = 32,
    parameter int             AW      = 10,
    parameter int             DEPTH   = 4,
    parameter logic [5:0]     HALT_OP = 6'b111111
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         prog_we,
    input  logic [AW-1:0]                prog_addr,
    input  logic [XLEN-1:0]              prog_data,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_ir,
    output logic [XLEN-1:0]              out_npc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [AW-1:0]   npc;
    } fetch_ent_t;

    logic [XLEN-1:0] imem [0:(1<<AW)-1];

    logic [AW-1:0]   pc;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_word;
    logic            halt_hit;
    logic [CW:0]     occ;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_ent_t      push_ent;
    fetch_ent_t      head_ent;
    logic            unused_redirect_hi;

    // Only the low AW bits of the branch target address the imem.
    assign unused_redirect_hi = ^redirect_pc[XLEN-1:AW];

    assign halt_hit = rd_valid && (rd_word[XLEN-1 -: 6] == HALT_OP);

    // In-flight read counts against capacity so a push never meets a full queue.
    assign occ   = {1'b0, count} + (CW+1)'(rd_valid);
    assign issue = !halted && !redirect && !prog_we && !halt_hit
                   && (occ < (CW+1)'(DEPTH));
    assign push  = rd_valid && !redirect;
    assign pop   = out_valid && out_ready;

    assign push_ent.ir  = rd_word;
    assign push_ent.npc = rd_addr + AW'(1);

    // Single-port imem: program writes take the port, otherwise a fetch reads it.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem[prog_addr] <= prog_data;
        end else if (issue) begin
            rd_word <= imem[pc];
        end
    end

    // PC, read-stage tag and halt flag; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            halted   <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc[AW-1:0];
            rd_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                rd_addr <= pc;
                pc      <= pc + AW'(1);
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end
        end
    end

    ifetch_fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_vld (out_valid),
        .head_dat (head_ent),
        .count    (count)
    );

    assign out_ir  = head_ent.ir;
    assign out_npc = {{(XLEN-AW){1'b0}}, head_ent.npc};
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic [2:0]  count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mm [1024];

    ifetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ir      (out_ir),
        .out_npc     (out_npc),
        .count       (count),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic void exp_push(input int a);
        exp_t e;
        e.ir  = mm[a];
        e.npc = 32'((a + 1) % 1024);
        sb.push_back(e);
    endfunction

    // One clock: scoreboard-check any handshake just before the edge, return #1 after it.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got ir=%h npc=%h, expected no delivery", out_ir, out_npc);
            end else begin
                e = sb.pop_front();
                if (out_ir !== e.ir || out_npc !== e.npc) begin
                    errors++;
                    $display("FAIL pop_data: got ir=%h npc=%h, expected ir=%h npc=%h",
                             out_ir, out_npc, e.ir, e.npc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #1;
        for (int a = 0; a < 1024; a++) begin
            mm[a]     = 32'(a);
            prog_we   = 1'b1;
            prog_addr = 10'(a);
            prog_data = 32'(a);
            cycle();
        end
        prog_we = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (out_ir !== 32'd0)   begin errors++; $display("FAIL reset_ir: got %h expected 0", out_ir); end
        checks++; if (out_npc !== 32'd0)  begin errors++; $display("FAIL reset_npc: got %h expected 0", out_npc); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) exp_push(a);
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1_valid: got %b expected 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_edge2_valid: got %b expected 1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: beat %0d got valid %b expected 1", i, out_valid); end
            cycle();
        end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_backpressure();
        int n;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (count !== 3'd4)     begin errors++; $display("FAIL bp_count_full: got %0d expected 4", count); end
        checks++; if (out_ir !== mm[0])   begin errors++; $display("FAIL bp_head: got %h expected %h", out_ir, mm[0]); end
        for (int i = 0; i < 5; i++) cycle();
        checks++; if (count !== 3'd4)     begin errors++; $display("FAIL bp_count_hold: got %0d expected 4", count); end
        for (int a = 0; a < 8; a++) exp_push(a);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 40) begin cycle(); n++; end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_redirect();
        int n;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
        exp_push(0);
        redirect = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
        cycle();
        redirect = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL redir_flush_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid: got %b expected 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_n2_valid: got %b expected 1", out_valid); end
        checks++; if (out_ir !== mm[32'h20] || out_npc !== 32'h21) begin
            errors++; $display("FAIL redir_target: got ir=%h npc=%h expected ir=%h npc=21", out_ir, out_npc, mm[32'h20]);
        end
        for (int a = 32'h20; a < 32'h24; a++) exp_push(a);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin cycle(); n++; end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_wrap();
        int n;
        redirect = 1'b1; redirect_pc = 32'd1023; out_ready = 1'b0;
        cycle();
        redirect = 1'b0;
        exp_push(1023); exp_push(0); exp_push(1);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin cycle(); n++; end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_halt();
        int n;
        rst_n = 1'b0; out_ready = 1'b0;
        mm[5] = 32'hFC00_0000;
        prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hFC00_0000;
        cycle();
        prog_we = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 6; a++) exp_push(a);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 30) begin cycle(); n++; end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_drain: got %0d left expected 0", sb.size()); sb.delete(); end
        for (int i = 0; i < 6; i++) cycle();
        checks++; if (halted !== 1'b1)    begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL halt_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b expected 0", out_valid); end
        checks++; if (out_ir !== 32'd0)   begin errors++; $display("FAIL halt_empty_ir: got %h expected 0", out_ir); end
        out_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'd0;
        cycle();
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
        for (int a = 0; a < 3; a++) exp_push(a);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin cycle(); n++; end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_resume: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        int n;
        for (int i = 0; i < 8; i++) cycle();
        checks++; if (out_valid !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got valid=%b halted=%b expected 1 1", out_valid, halted);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL areset_halted: got %b expected 0", halted); end
        checks++; if (out_ir !== 32'd0)   begin errors++; $display("FAIL areset_ir: got %h expected 0", out_ir); end
        cycle();
        rst_n = 1'b1;
        for (int a = 0; a < 6; a++) exp_push(a);
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 30) begin cycle(); n++; end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL areset_restart: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
